// File: rtl/axis_switch_scheduler.sv
// ============================================================================
// axis_switch_scheduler : frame-aligned select sequencer for signal_switch
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_switch_scheduler #(
  parameter int COUNT_WIDTH        = 16,
  parameter int BLANK_CYCLES       = 2,
  parameter int SWITCH_COUNT_WIDTH = 8
) (
  input  logic                          aclk,
  input  logic                          reset,
  input  logic                          mode,
  input  logic                          manual_sel,
  input  logic [COUNT_WIDTH-1:0]        dwell_a,
  input  logic [COUNT_WIDTH-1:0]        dwell_b,
  input  logic                          frame_boundary,
  output logic                          switch,
  output logic                          blank,
  output logic                          pending,
  output logic [SWITCH_COUNT_WIDTH-1:0] switch_count
);

  typedef enum logic [1:0] {
    ST_HOLD          = 2'd0,
    ST_WAIT_BOUNDARY = 2'd1,
    ST_BLANK         = 2'd2
  } state_t;

  localparam logic [3:0] C_BLANK_LOAD = 4'(BLANK_CYCLES - 1);

  state_t                          state_q, state_d;
  logic [COUNT_WIDTH-1:0]          cnt_q, cnt_d;
  logic [3:0]                      blank_cnt_q, blank_cnt_d;
  logic                            switch_q, switch_d;
  logic                            blank_q, blank_d;
  logic                            pending_q, pending_d;
  logic [SWITCH_COUNT_WIDTH-1:0]   switch_count_q, switch_count_d;

  logic [COUNT_WIDTH-1:0]          dwell_cur;
  logic [COUNT_WIDTH-1:0]          dwell_m1;
  logic                            request;

  // A zero dwell behaves as one cycle, so the threshold never underflows.
  always_comb begin
    dwell_cur = switch_q ? dwell_b : dwell_a;
    dwell_m1  = (dwell_cur == '0) ? '0 : dwell_cur - 1'b1;
    request   = mode ? (cnt_q >= dwell_m1) : (manual_sel != switch_q);
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    blank_cnt_d    = blank_cnt_q;
    switch_d       = switch_q;
    blank_d        = blank_q;
    switch_count_d = switch_count_q;

    case (state_q)
      ST_HOLD: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (request && frame_boundary) begin
          state_d     = ST_BLANK;
          switch_d    = ~switch_q;
          blank_d     = 1'b1;
          blank_cnt_d = C_BLANK_LOAD;
        end else if (request) begin
          state_d = ST_WAIT_BOUNDARY;
        end
      end

      ST_WAIT_BOUNDARY: begin
        if (!request) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (frame_boundary) begin
          state_d     = ST_BLANK;
          switch_d    = ~switch_q;
          blank_d     = 1'b1;
          blank_cnt_d = C_BLANK_LOAD;
        end
      end

      ST_BLANK: begin
        if (blank_cnt_q == 4'd0) begin
          state_d        = ST_HOLD;
          cnt_d          = '0;
          blank_d        = 1'b0;
          switch_count_d = switch_count_q + 1'b1;
        end else begin
          blank_cnt_d = blank_cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
        blank_d = 1'b0;
      end
    endcase

    pending_d = (state_d == ST_WAIT_BOUNDARY);
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q        <= ST_HOLD;
      cnt_q          <= '0;
      blank_cnt_q    <= 4'd0;
      switch_q       <= 1'b0;
      blank_q        <= 1'b0;
      pending_q      <= 1'b0;
      switch_count_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      blank_cnt_q    <= blank_cnt_d;
      switch_q       <= switch_d;
      blank_q        <= blank_d;
      pending_q      <= pending_d;
      switch_count_q <= switch_count_d;
    end
  end

  assign switch       = switch_q;
  assign blank        = blank_q;
  assign pending      = pending_q;
  assign switch_count = switch_count_q;

endmodule

`default_nettype wire
